// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: request field layout,
// arbitration FSM states and grant-counter width.
package mem_arbiter_pkg;

    // Request word layout is {we, wdata, addr}; addr occupies the LSBs.
    localparam int REQ_ADDR_LSB = 0;

    // Width and saturation value of the per-requester grant counters.
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // IDLE arbitrates freely; HOLD keeps a stalled grant until accepted.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // LSB of the write-data field inside a request word.
    function automatic int req_wdata_lsb(input int w_addr);
        return w_addr;
    endfunction

    // Position of the write-enable bit (MSB) inside a request word.
    function automatic int req_we_bit(input int w_addr, input int w_data);
        return w_addr + w_data;
    endfunction

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding read, so
// in-order read data can be steered back to the right requester.
module mem_arbiter_tag_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] tag,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  slot_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // Pointer advance with explicit wrap at DEPTH.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == '0);
    assign rd_en_s = pop & ~empty;
    // A push into a full FIFO is only accepted when a pop frees a slot.
    assign wr_en_s = push & (~full | rd_en_s);
    assign head    = slot_r[rd_ptr_r];

    // Tag storage: write the pushed tag at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            slot_r[wr_ptr_r] <= tag;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ requesters,
// with in-order read-data return steered by a tag FIFO.
// Optional feature: define MEM_ARBITER_STATS_EN to add the grant_cnt
// output (saturating 16-bit handshake counters per requester).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int W_DATA    = 16,
    parameter int W_ADDR    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ*(W_DATA+W_ADDR+1)-1:0] req_data,
    output logic [N_REQ-1:0]                   dout_valid,
    input  logic [N_REQ-1:0]                   dout_ready,
    output logic [W_DATA-1:0]                  dout_data,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [W_DATA+W_ADDR:0]             mem_req_data,
    input  logic                               mem_dout_valid,
    output logic                               mem_dout_ready,
    input  logic [W_DATA-1:0]                  mem_dout_data,
    output logic                               err
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]             grant_cnt
`endif
);

    localparam int TAG_W  = $clog2(N_REQ);
    localparam int REQ_W  = W_DATA + W_ADDR + 1;
    localparam int WE_BIT = req_we_bit(W_ADDR, W_DATA);

    arb_state_t       state_r;
    arb_state_t       state_nxt_s;
    logic [TAG_W-1:0] ptr_r;
    logic [TAG_W-1:0] hold_idx_r;
    logic [N_REQ-1:0] elig_s;
    logic             scan_found_s;
    logic [TAG_W-1:0] scan_idx_s;
    int               best_dist_s;
    int               cand_dist_s;
    logic [TAG_W-1:0] gnt_idx_s;
    logic             gnt_any_s;
    logic [REQ_W-1:0] gnt_data_s;
    logic             mem_req_valid_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             req_hs_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [TAG_W-1:0] fifo_head_s;
    logic [N_REQ-1:0] dout_valid_s;
    logic             head_ready_s;
    logic             mem_dout_ready_s;
    logic             err_r;

    // Eligibility: writes always, reads only while the tag FIFO has room.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig_s[i] = req_valid[i] & (req_data[i*REQ_W + WE_BIT] | ~fifo_full_s);
        end
    end

    // Round-robin scan: nearest eligible requester at or above ptr_r.
    always_comb begin
        scan_found_s = 1'b0;
        scan_idx_s   = '0;
        best_dist_s  = N_REQ;
        cand_dist_s  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_dist_s = (i >= int'(ptr_r)) ? (i - int'(ptr_r)) : (i + N_REQ - int'(ptr_r));
            if (elig_s[i] && (cand_dist_s < best_dist_s)) begin
                best_dist_s  = cand_dist_s;
                scan_idx_s   = TAG_W'(i);
                scan_found_s = 1'b1;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a stalled grant parks in HOLD until memory accepts it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_req_valid_s && !mem_req_ready) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (mem_req_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: grant selection, request mux and per-requester accept.
    always_comb begin
        gnt_idx_s = scan_idx_s;
        gnt_any_s = scan_found_s;
        case (state_r)
            IDLE: begin
                gnt_idx_s = scan_idx_s;
                gnt_any_s = scan_found_s;
            end
            HOLD: begin
                gnt_idx_s = hold_idx_r;
                gnt_any_s = 1'b1;
            end
            default: begin
                gnt_idx_s = scan_idx_s;
                gnt_any_s = 1'b0;
            end
        endcase
        mem_req_valid_s = rst & gnt_any_s;
        gnt_data_s      = '0;
        req_ready_s     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx_s == TAG_W'(i)) begin
                gnt_data_s     = req_data[i*REQ_W +: REQ_W];
                req_ready_s[i] = mem_req_valid_s & mem_req_ready;
            end else begin
                req_ready_s[i] = 1'b0;
            end
        end
    end

    assign req_hs_s      = mem_req_valid_s & mem_req_ready;
    assign fifo_push_s   = req_hs_s & ~gnt_data_s[WE_BIT];
    assign mem_req_valid = mem_req_valid_s;
    assign mem_req_data  = gnt_data_s;
    assign req_ready     = req_ready_s;

    // Latch the stalled grant index when entering HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_idx_r <= '0;
        end else if ((state_r == IDLE) && (state_nxt_s == HOLD)) begin
            hold_idx_r <= scan_idx_s;
        end
    end

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (req_hs_s) begin
            ptr_r <= (gnt_idx_s == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx_s + TAG_W'(1);
        end
    end

    mem_arbiter_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .tag   (gnt_idx_s),
        .pop   (fifo_pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // Response steering: route read data to the head tag; drain strays.
    always_comb begin
        dout_valid_s = '0;
        head_ready_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fifo_head_s == TAG_W'(i)) begin
                dout_valid_s[i] = rst & ~fifo_empty_s & mem_dout_valid;
                head_ready_s    = dout_ready[i];
            end else begin
                dout_valid_s[i] = 1'b0;
            end
        end
        if (!rst) begin
            mem_dout_ready_s = 1'b0;
        end else if (fifo_empty_s) begin
            mem_dout_ready_s = mem_dout_valid;
        end else begin
            mem_dout_ready_s = head_ready_s;
        end
    end

    assign fifo_pop_s     = rst & ~fifo_empty_s & mem_dout_valid & head_ready_s;
    assign dout_valid     = dout_valid_s;
    assign mem_dout_ready = mem_dout_ready_s;
    assign dout_data      = mem_dout_data;

    // Sticky error: read data arrived with no read outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (mem_dout_valid && fifo_empty_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;

`ifdef MEM_ARBITER_STATS_EN
    logic [N_REQ*CNT_W-1:0] grant_cnt_r;

    // Saturating per-requester handshake counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_r <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_hs_s && (gnt_idx_s == TAG_W'(i)) &&
                    (grant_cnt_r[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    grant_cnt_r[i*CNT_W +: CNT_W] <= grant_cnt_r[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: rotation, HOLD stability, read
// return ordering, FIFO-full blocking, error flag and reset behaviour.
module tb_mem_arbiter;

    localparam int N_REQ     = 4;
    localparam int W_DATA    = 16;
    localparam int W_ADDR    = 16;
    localparam int TAG_DEPTH = 4;
    localparam int REQ_W     = W_DATA + W_ADDR + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*REQ_W-1:0] req_data;
    logic [N_REQ-1:0]       dout_valid;
    logic [N_REQ-1:0]       dout_ready;
    logic [W_DATA-1:0]      dout_data;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [REQ_W-1:0]       mem_req_data;
    logic                   mem_dout_valid;
    logic                   mem_dout_ready;
    logic [W_DATA-1:0]      mem_dout_data;
    logic                   err;
`ifdef MEM_ARBITER_STATS_EN
    logic [N_REQ*16-1:0]    grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .N_REQ     (N_REQ),
        .W_DATA    (W_DATA),
        .W_ADDR    (W_ADDR),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_data      (dout_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_data   (mem_req_data),
        .mem_dout_valid (mem_dout_valid),
        .mem_dout_ready (mem_dout_ready),
        .mem_dout_data  (mem_dout_data),
        .err            (err)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .grant_cnt      (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] pk(input logic we, input logic [15:0] wd, input logic [15:0] a);
        return {we, wd, a};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [REQ_W-1:0] d);
        req_valid[i] = v;
        req_data[i*REQ_W +: REQ_W] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 4'hF; req_data = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, pk(1'b1, 16'h0, 16'(i)));
        mem_req_ready = 1'b1; mem_dout_valid = 1'b1; dout_ready = 4'hF; mem_dout_data = 16'h1234;
        #2;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_req_valid: got %b expected 0", mem_req_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        checks++; if (dout_valid !== 4'b0000) begin failures++; $display("FAIL rst_dout_valid: got %b expected 0000", dout_valid); end
        checks++; if (mem_dout_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_dout_ready: got %b expected 0", mem_dout_ready); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", err); end
        req_valid = '0; mem_req_ready = 1'b0; mem_dout_valid = 1'b0; dout_ready = '0;
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] e;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, pk(1'b1, 16'(16'h1000 + i), 16'(16'h0100 + i)));
        mem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            #1;
            checks++; if (req_ready !== e) begin failures++; $display("FAIL rotation_ready%0d: got %b expected %b", k, req_ready, e); end
            checks++; if (mem_req_data !== pk(1'b1, 16'(16'h1000 + k % 4), 16'(16'h0100 + k % 4))) begin
                failures++; $display("FAIL rotation_data%0d: got %h expected requester %0d slice", k, mem_req_data, k % 4); end
            next_cycle();
        end
        req_valid = '0; mem_req_ready = 1'b0;
    endtask

    task automatic test_hold();
        set_req(2, 1'b1, pk(1'b1, 16'h2222, 16'h0222));
        mem_req_ready = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b1 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL hold_entry: got valid=%b ready=%b expected valid=1 ready=0000", mem_req_valid, req_ready); end
        next_cycle();
        set_req(0, 1'b1, pk(1'b1, 16'h0000, 16'h0000));
        set_req(1, 1'b1, pk(1'b1, 16'h1111, 16'h0111));
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (mem_req_data !== pk(1'b1, 16'h2222, 16'h0222) || req_ready !== 4'b0000) begin
                failures++; $display("FAIL hold_stable%0d: got data=%h ready=%b expected requester 2 ready=0000", c, mem_req_data, req_ready); end
            if (c < 2) next_cycle();
        end
        mem_req_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL hold_release: got %b expected 0100", req_ready); end
        next_cycle();
        set_req(2, 1'b0, pk(1'b1, 16'h2222, 16'h0222));
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL hold_next: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = '0; mem_req_ready = 1'b0;
    endtask

    task automatic test_read_order();
        set_req(1, 1'b1, pk(1'b0, 16'h0, 16'h0010));
        set_req(3, 1'b1, pk(1'b0, 16'h0, 16'h0020));
        mem_req_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010 || mem_req_data !== pk(1'b0, 16'h0, 16'h0010)) begin
            failures++; $display("FAIL read_req1: got ready=%b data=%h expected 0010 addr 0010", req_ready, mem_req_data); end
        next_cycle();
        set_req(1, 1'b0, pk(1'b0, 16'h0, 16'h0010));
        #1;
        checks++; if (req_ready !== 4'b1000 || mem_req_data !== pk(1'b0, 16'h0, 16'h0020)) begin
            failures++; $display("FAIL read_req3: got ready=%b data=%h expected 1000 addr 0020", req_ready, mem_req_data); end
        next_cycle();
        set_req(3, 1'b0, pk(1'b0, 16'h0, 16'h0020));
        mem_req_ready = 1'b0;
        mem_dout_valid = 1'b1; mem_dout_data = 16'hAAAA; dout_ready = 4'b0000;
        #1;
        checks++; if (dout_valid !== 4'b0010 || dout_data !== 16'hAAAA) begin
            failures++; $display("FAIL read_resp1: got valid=%b data=%h expected 0010 aaaa", dout_valid, dout_data); end
        checks++; if (mem_dout_ready !== 1'b0) begin failures++; $display("FAIL read_backpressure: got %b expected 0", mem_dout_ready); end
        next_cycle();
        dout_ready = 4'b0010;
        #1;
        checks++; if (mem_dout_ready !== 1'b1 || dout_valid !== 4'b0010) begin
            failures++; $display("FAIL read_accept1: got ready=%b valid=%b expected 1 0010", mem_dout_ready, dout_valid); end
        next_cycle();
        mem_dout_data = 16'hBBBB; dout_ready = 4'b1000;
        #1;
        checks++; if (dout_valid !== 4'b1000 || dout_data !== 16'hBBBB || mem_dout_ready !== 1'b1) begin
            failures++; $display("FAIL read_resp3: got valid=%b data=%h ready=%b expected 1000 bbbb 1", dout_valid, dout_data, mem_dout_ready); end
        next_cycle();
        mem_dout_valid = 1'b0; dout_ready = '0;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL read_no_err: got %b expected 0", err); end
    endtask

    task automatic test_fifo_full();
        logic [3:0] exp_tags [4];
        exp_tags[0] = 4'b1000; exp_tags[1] = 4'b1000; exp_tags[2] = 4'b1000; exp_tags[3] = 4'b0001;
        set_req(3, 1'b1, pk(1'b0, 16'h0, 16'h0030));
        mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL full_fill%0d: got %b expected 1000", k, req_ready); end
            next_cycle();
        end
        set_req(3, 1'b0, pk(1'b0, 16'h0, 16'h0030));
        set_req(0, 1'b1, pk(1'b0, 16'h0, 16'h0040));
        set_req(2, 1'b1, pk(1'b1, 16'h5555, 16'h0050));
        #1;
        checks++; if (req_ready !== 4'b0100 || mem_req_data !== pk(1'b1, 16'h5555, 16'h0050)) begin
            failures++; $display("FAIL full_write_passes: got ready=%b data=%h expected 0100 requester 2", req_ready, mem_req_data); end
        next_cycle();
        set_req(2, 1'b0, pk(1'b1, 16'h5555, 16'h0050));
        #1;
        checks++; if (mem_req_valid !== 1'b0 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL full_read_blocked: got valid=%b ready=%b expected 0 0000", mem_req_valid, req_ready); end
        next_cycle();
        mem_dout_valid = 1'b1; mem_dout_data = 16'h3333; dout_ready = 4'b1000;
        #1;
        checks++; if (dout_valid !== 4'b1000) begin failures++; $display("FAIL full_pop_head: got %b expected 1000", dout_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_same_cycle_pop: got %b expected 0", mem_req_valid); end
        next_cycle();
        mem_dout_valid = 1'b0; dout_ready = '0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL full_read_after_pop: got %b expected 0001", req_ready); end
        next_cycle();
        set_req(0, 1'b0, pk(1'b0, 16'h0, 16'h0040));
        mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_dout_valid = 1'b1; dout_ready = 4'hF;
            #1;
            checks++; if (dout_valid !== exp_tags[k]) begin failures++; $display("FAIL full_drain%0d: got %b expected %b", k, dout_valid, exp_tags[k]); end
            next_cycle();
        end
        mem_dout_valid = 1'b0; dout_ready = '0;
    endtask

    task automatic test_err();
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_initial: got %b expected 0", err); end
        mem_dout_valid = 1'b1; mem_dout_data = 16'hDEAD;
        #1;
        checks++; if (mem_dout_ready !== 1'b1 || dout_valid !== 4'b0000) begin
            failures++; $display("FAIL err_discard: got ready=%b valid=%b expected 1 0000", mem_dout_ready, dout_valid); end
        next_cycle();
        mem_dout_valid = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", err); end
        repeat (3) next_cycle();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
        rst = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared: got %b expected 0", err); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_drop();
        set_req(1, 1'b1, pk(1'b0, 16'h0, 16'h0070));
        mem_req_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL drop_issue: got %b expected 0010", req_ready); end
        next_cycle();
        req_valid = '0; mem_req_ready = 1'b0;
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        mem_dout_valid = 1'b1; dout_ready = 4'hF;
        #1;
        checks++; if (dout_valid !== 4'b0000 || mem_dout_ready !== 1'b1) begin
            failures++; $display("FAIL drop_no_tag: got valid=%b ready=%b expected 0000 1", dout_valid, mem_dout_ready); end
        next_cycle();
        mem_dout_valid = 1'b0; dout_ready = '0;
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL drop_err: got %b expected 1", err); end
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

`ifdef MEM_ARBITER_STATS_EN
    task automatic test_stats();
        set_req(0, 1'b1, pk(1'b1, 16'h0, 16'h0000));
        mem_req_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        req_valid = '0; mem_req_ready = 1'b0;
        checks++; if (grant_cnt[15:0] !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate: got %h expected ffff", grant_cnt[15:0]); end
        checks++; if (grant_cnt[31:16] !== 16'h0000) begin failures++; $display("FAIL stats_other: got %h expected 0000", grant_cnt[31:16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_read_order();
        test_fifo_full();
        test_err();
        test_reset_drop();
`ifdef MEM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
